pwm_key_ctrl: RTL

Front-panel input stage of the multi-channel PWM generator. Debounces three raw push-buttons (UP, DOWN, SELECT) on the slow sample tick from the prescaler. Turns presses and holds into single-cycle ADD/DEC command pulses, with auto-repeat. Maintains the index of the channel those commands target, and drives the channel selector and per-channel bidirectional duty counters directly.

---
 rtl/pwm_key_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_key_ctrl.sv
// pwm_key_ctrl: front-panel button stage for the PWM generator.
// Synchronizes and debounces UP/DN/SELECT, turns UP/DN presses and holds
// into single-cycle ADD/DEC pulses with auto-repeat, and tracks the
// selected channel index.
//
// Repeat FSM (one instance each for UP and DN)
//   state    | meaning
//   S_IDLE   | no command pending; waiting for a fresh press event
//   S_HOLD   | press pulse sent; counting REP_DLY CE ticks to first repeat
//   S_REPEAT | auto-repeating; a pulse every REP_RATE CE ticks
module pwm_key_ctrl #(
  parameter int L_BIT    = 4,
  parameter int N_CH     = 4,
  parameter int REP_DLY  = 250,
  parameter int REP_RATE = 50
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_SEL,
  output logic [1:0] DRV,
  output logic [1:0] SEL,
  output logic [2:0] KEY_LVL
);

  localparam logic [15:0] DLY_TC  = 16'(REP_DLY - 1);
  localparam logic [15:0] RATE_TC = 16'(REP_RATE - 1);
  localparam logic [1:0]  SEL_MAX = 2'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} rep_state_e;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [L_BIT-1:0] sh_q [3];
  logic [L_BIT-1:0] sh_d [3];
  logic [2:0]       lvl_q, lvl_d;
  logic [2:0]       press;
  logic [1:0]       rel;
  logic             lockout;
  rep_state_e       st_q [2];
  rep_state_e       st_d [2];
  logic [15:0]      cnt_q [2];
  logic [15:0]      cnt_d [2];
  logic [1:0]       pulse;
  logic [1:0]       drv_q, drv_d;
  logic [1:0]       sel_q, sel_d;

  // bit order {SEL, DN, UP} matches KEY_LVL
  assign btn_raw = {BTN_SEL, BTN_DN, BTN_UP};

  // Shift in the synchronized sample on CE; level follows only a full run of equal samples
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      sh_d[b]  = sh_q[b];
      lvl_d[b] = lvl_q[b];
      if (CE) begin
        sh_d[b] = {sh_q[b][L_BIT-2:0], sync2_q[b]};
        if (&sh_d[b]) begin
          lvl_d[b] = 1'b1;
        end else if (~|sh_d[b]) begin
          lvl_d[b] = 1'b0;
        end
      end
    end
  end

  // Events are taken from the level being written this cycle so outputs land one CLK later
  assign press   = lvl_d & ~lvl_q;
  assign rel     = lvl_q[1:0] & ~lvl_d[1:0];
  assign lockout = lvl_d[0] & lvl_d[1];

  // Synchronizers, debounce shift registers and debounced levels
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      for (int b = 0; b < 3; b++) sh_q[b] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      for (int b = 0; b < 3; b++) sh_q[b] <= sh_d[b];
    end
  end

  // Repeat FSM next state, counter and pulse for UP (0) and DN (1)
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      pulse[i] = 1'b0;
      if (lockout) begin
        // both held: drop to IDLE so only a fresh press re-arms the button
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          S_IDLE: begin
            if (press[i]) begin
              pulse[i] = 1'b1;
              cnt_d[i] = '0;
              st_d[i]  = S_HOLD;
            end
          end
          S_HOLD: begin
            if (rel[i]) begin
              st_d[i]  = S_IDLE;
              cnt_d[i] = '0;
            end else if (CE) begin
              if (cnt_q[i] == DLY_TC) begin
                pulse[i] = 1'b1;
                cnt_d[i] = '0;
                st_d[i]  = S_REPEAT;
              end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          S_REPEAT: begin
            if (rel[i]) begin
              st_d[i]  = S_IDLE;
              cnt_d[i] = '0;
            end else if (CE) begin
              if (cnt_q[i] == RATE_TC) begin
                pulse[i] = 1'b1;
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          default: begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state and counter registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Command and channel select: a channel change in the same cycle drops the command
  always_comb begin
    drv_d = pulse;
    sel_d = sel_q;
    if ((&pulse) || press[2]) begin
      drv_d = 2'b00;
    end
    if (press[2]) begin
      sel_d = (sel_q == SEL_MAX) ? 2'd0 : sel_q + 2'd1;
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      drv_q <= 2'b00;
      sel_q <= 2'd0;
    end else begin
      drv_q <= drv_d;
      sel_q <= sel_d;
    end
  end

  assign DRV     = drv_q;
  assign SEL     = sel_q;
  assign KEY_LVL = lvl_q;

endmodule
